// File: rtl/gate_sched_pkg.sv
// gate_sched_pkg: shared state encoding, parameter defaults and channel pick helper
package gate_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int LEN_W_DEF   = 16;
    localparam int GUARD_W_DEF = 8;

    typedef enum logic [2:0] {IDLE, SELECT, ON, GUARD, DONE} state_t;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// sched_timer: loadable down-counter with zero flag, shared by window and guard timing
module sched_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= val;
        else if (!zero) cnt <= cnt - W'(1);
    end

    assign zero = cnt == '0;

endmodule

// File: rtl/channel_gate_scheduler.sv
// channel_gate_scheduler: time-multiplexed channel gating frames; GATE_SCHED_CONTINUOUS_EN enables wrap-around runs
module channel_gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int GUARD_W = GUARD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [LEN_W-1:0]     on_len,
    input  logic [GUARD_W-1:0]   guard_len,
    input  logic                 cont,
    input  logic [32*N_CH-1:0]   in_bus,
    output logic [N_CH-1:0]      mode,
    output logic [31:0]          out_bus,
    output logic [2:0]           active_ch,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = LEN_W > GUARD_W ? LEN_W : GUARD_W;
`ifdef GATE_SCHED_CONTINUOUS_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    state_t            state, nxt;
    logic [N_CH-1:0]   en_q, rem, avail, pick_oh;
    logic [LEN_W-1:0]  len_q;
    logic [GUARD_W-1:0] grd_q;
    logic              cont_q, load, zero;
    logic [TW-1:0]     val;
    logic [2:0]        pick;

    // Remaining channels this pass; an exhausted pass reloads the mask only in continuous runs
    assign avail   = |rem ? rem : (cont_q ? en_q : '0);
    assign pick    = lowest(8'(avail));
    assign pick_oh = N_CH'(1) << pick;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? SELECT : IDLE;
            SELECT:  nxt = (avail == '0 || len_q == '0) ? (cont_q ? SELECT : DONE) : ON;
            ON:      nxt = zero ? (grd_q > GUARD_W'(1) ? GUARD : SELECT) : ON;
            GUARD:   nxt = zero ? SELECT : GUARD;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    // SELECT supplies one dead cycle, so GUARD itself covers the remaining guard_len-1
    assign load = (state == SELECT && nxt == ON) || (state == ON && nxt == GUARD);
    assign val  = state == SELECT ? TW'(len_q - LEN_W'(1)) : TW'(grd_q - GUARD_W'(2));

    sched_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .val   (val),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_q      <= '0;
            rem       <= '0;
            len_q     <= '0;
            grd_q     <= '0;
            cont_q    <= 1'b0;
            active_ch <= 3'd0;
            mode      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= nxt != IDLE;
            done  <= nxt == DONE;
            mode  <= (state == ON && !abort) ? N_CH'(1) << active_ch : '0;
            if (state == IDLE && nxt == SELECT) begin
                en_q   <= ch_en;
                rem    <= ch_en;
                len_q  <= on_len;
                grd_q  <= guard_len;
                cont_q <= cont & CONT_EN;
            end
            if (state == SELECT && nxt == ON) begin
                active_ch <= pick;
                rem       <= avail & ~pick_oh;
            end
        end
    end

    always_comb begin
        out_bus = '0;
        for (int i = 0; i < N_CH; i++) if (mode[i]) out_bus = in_bus[32*i +: 32];
    end

endmodule
